// File: rtl/rocket_axi_pkg.sv
// Shared AXI encodings and bridge FSM states for rocket_mem_to_axi.
package rocket_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4
  } mem_state_e;

  // SLVERR and DECERR both carry bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/rocket_mem_to_axi.sv
// Single-beat memory request port to AXI4 master bridge, one transaction
// outstanding at a time. Optional macro ROCKET_MEM_TO_AXI_ERR_EN adds err_o,
// which flags SLVERR/DECERR responses alongside rvalid_o.
module rocket_mem_to_axi
  import rocket_axi_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // Request side
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [7:0]                  be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
  output logic                        err_o,
`endif
  // AXI write address
  output logic                        axi4_mem_0_bits_aw_valid,
  input  logic                        axi4_mem_0_bits_aw_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi4_mem_0_bits_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi4_mem_0_bits_aw_addr,
  output logic [7:0]                  axi4_mem_0_bits_aw_len,
  output logic [2:0]                  axi4_mem_0_bits_aw_size,
  output logic [1:0]                  axi4_mem_0_bits_aw_burst,
  output logic                        axi4_mem_0_bits_aw_lock,
  output logic [3:0]                  axi4_mem_0_bits_aw_cache,
  output logic [2:0]                  axi4_mem_0_bits_aw_prot,
  output logic [3:0]                  axi4_mem_0_bits_aw_qos,
  // AXI write data
  output logic                        axi4_mem_0_bits_w_valid,
  input  logic                        axi4_mem_0_bits_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi4_mem_0_bits_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi4_mem_0_bits_w_strb,
  output logic                        axi4_mem_0_bits_w_last,
  // AXI write response
  input  logic                        axi4_mem_0_bits_b_valid,
  output logic                        axi4_mem_0_bits_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi4_mem_0_bits_b_id,
  input  logic [1:0]                  axi4_mem_0_bits_b_resp,
  // AXI read address
  output logic                        axi4_mem_0_bits_ar_valid,
  input  logic                        axi4_mem_0_bits_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi4_mem_0_bits_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi4_mem_0_bits_ar_addr,
  output logic [7:0]                  axi4_mem_0_bits_ar_len,
  output logic [2:0]                  axi4_mem_0_bits_ar_size,
  output logic [1:0]                  axi4_mem_0_bits_ar_burst,
  output logic                        axi4_mem_0_bits_ar_lock,
  output logic [3:0]                  axi4_mem_0_bits_ar_cache,
  output logic [2:0]                  axi4_mem_0_bits_ar_prot,
  output logic [3:0]                  axi4_mem_0_bits_ar_qos,
  // AXI read data
  input  logic                        axi4_mem_0_bits_r_valid,
  output logic                        axi4_mem_0_bits_r_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi4_mem_0_bits_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi4_mem_0_bits_r_data,
  input  logic [1:0]                  axi4_mem_0_bits_r_resp,
  input  logic                        axi4_mem_0_bits_r_last
);

  localparam int unsigned    STRB_W   = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]     AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

  mem_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]                be_q, be_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      r_ready_q, r_ready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = aw_valid_q & axi4_mem_0_bits_aw_ready;
  assign w_hs  = w_valid_q  & axi4_mem_0_bits_w_ready;
  assign ar_hs = ar_valid_q & axi4_mem_0_bits_ar_ready;
  assign b_hs  = b_ready_q  & axi4_mem_0_bits_b_valid;
  assign r_hs  = r_ready_q  & axi4_mem_0_bits_r_valid;

  // Grant is combinational so a request is accepted in the cycle it is seen.
  assign gnt_o = (state_q == IDLE) & req_i;

  // State register plus transaction latch and registered AXI controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic; valids only change on handshakes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d = addr_i;
          data_d = data_i;
          be_d   = be_i;
          if (we_i) begin
            state_d    = WRITE;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = READ;
            ar_valid_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = WAIT_B;
          b_ready_d = 1'b1;
        end
      end

      WAIT_B: begin
        if (b_hs) begin
          state_d   = IDLE;
          b_ready_d = 1'b0;
          rvalid_d  = 1'b1;
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
          err_d     = resp_is_err(axi4_mem_0_bits_b_resp);
`endif
        end
      end

      READ: begin
        if (ar_hs) begin
          state_d    = WAIT_R;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end

      WAIT_R: begin
        if (r_hs) begin
          state_d   = IDLE;
          r_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = axi4_mem_0_bits_r_data;
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
          err_d     = resp_is_err(axi4_mem_0_bits_r_resp);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Completion side.
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

`ifdef ROCKET_MEM_TO_AXI_ERR_EN
  assign err_o = err_q;
  logic unused_resp;
  assign unused_resp = ^{axi4_mem_0_bits_b_id, axi4_mem_0_bits_r_id,
                         axi4_mem_0_bits_r_last};
`else
  logic unused_resp;
  assign unused_resp = ^{axi4_mem_0_bits_b_id, axi4_mem_0_bits_r_id,
                         axi4_mem_0_bits_r_last, axi4_mem_0_bits_b_resp,
                         axi4_mem_0_bits_r_resp, err_q};
`endif

  // Single-beat INCR encoding shared by both address channels.
  assign axi4_mem_0_bits_aw_valid = aw_valid_q;
  assign axi4_mem_0_bits_aw_id    = ID_VAL;
  assign axi4_mem_0_bits_aw_addr  = addr_q;
  assign axi4_mem_0_bits_aw_len   = 8'd0;
  assign axi4_mem_0_bits_aw_size  = AXI_SIZE;
  assign axi4_mem_0_bits_aw_burst = BURST_INCR;
  assign axi4_mem_0_bits_aw_lock  = 1'b0;
  assign axi4_mem_0_bits_aw_cache = 4'd0;
  assign axi4_mem_0_bits_aw_prot  = 3'd0;
  assign axi4_mem_0_bits_aw_qos   = 4'd0;

  assign axi4_mem_0_bits_w_valid  = w_valid_q;
  assign axi4_mem_0_bits_w_data   = data_q;
  assign axi4_mem_0_bits_w_strb   = STRB_W'(be_q);
  assign axi4_mem_0_bits_w_last   = 1'b1;

  assign axi4_mem_0_bits_b_ready  = b_ready_q;

  assign axi4_mem_0_bits_ar_valid = ar_valid_q;
  assign axi4_mem_0_bits_ar_id    = ID_VAL;
  assign axi4_mem_0_bits_ar_addr  = addr_q;
  assign axi4_mem_0_bits_ar_len   = 8'd0;
  assign axi4_mem_0_bits_ar_size  = AXI_SIZE;
  assign axi4_mem_0_bits_ar_burst = BURST_INCR;
  assign axi4_mem_0_bits_ar_lock  = 1'b0;
  assign axi4_mem_0_bits_ar_cache = 4'd0;
  assign axi4_mem_0_bits_ar_prot  = 3'd0;
  assign axi4_mem_0_bits_ar_qos   = 4'd0;

  assign axi4_mem_0_bits_r_ready  = r_ready_q;

endmodule

// File: tb/tb_rocket_mem_to_axi.sv
// Scoreboard bench for rocket_mem_to_axi: stimulus pushes expected beats and
// completions, a monitor pops and compares as the DUT presents them.
module tb_rocket_mem_to_axi;

  localparam int unsigned IDW = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned SW  = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [7:0]    be_i;
  logic [DW-1:0] data_i;
  logic          gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
  logic          err_o;
`endif

  logic           aw_valid, aw_ready, aw_lock;
  logic [IDW-1:0] aw_id;
  logic [AW-1:0]  aw_addr;
  logic [7:0]     aw_len;
  logic [2:0]     aw_size, aw_prot;
  logic [1:0]     aw_burst;
  logic [3:0]     aw_cache, aw_qos;
  logic           w_valid, w_ready, w_last;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic           b_valid, b_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           ar_valid, ar_ready, ar_lock;
  logic [IDW-1:0] ar_id;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  logic [2:0]     ar_size, ar_prot;
  logic [1:0]     ar_burst;
  logic [3:0]     ar_cache, ar_qos;
  logic           r_valid, r_ready, r_last;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;

  rocket_mem_to_axi #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID(0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .be_i(be_i), .data_i(data_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
    .err_o(err_o),
`endif
    .axi4_mem_0_bits_aw_valid(aw_valid), .axi4_mem_0_bits_aw_ready(aw_ready),
    .axi4_mem_0_bits_aw_id(aw_id), .axi4_mem_0_bits_aw_addr(aw_addr),
    .axi4_mem_0_bits_aw_len(aw_len), .axi4_mem_0_bits_aw_size(aw_size),
    .axi4_mem_0_bits_aw_burst(aw_burst), .axi4_mem_0_bits_aw_lock(aw_lock),
    .axi4_mem_0_bits_aw_cache(aw_cache), .axi4_mem_0_bits_aw_prot(aw_prot),
    .axi4_mem_0_bits_aw_qos(aw_qos),
    .axi4_mem_0_bits_w_valid(w_valid), .axi4_mem_0_bits_w_ready(w_ready),
    .axi4_mem_0_bits_w_data(w_data), .axi4_mem_0_bits_w_strb(w_strb),
    .axi4_mem_0_bits_w_last(w_last),
    .axi4_mem_0_bits_b_valid(b_valid), .axi4_mem_0_bits_b_ready(b_ready),
    .axi4_mem_0_bits_b_id(b_id), .axi4_mem_0_bits_b_resp(b_resp),
    .axi4_mem_0_bits_ar_valid(ar_valid), .axi4_mem_0_bits_ar_ready(ar_ready),
    .axi4_mem_0_bits_ar_id(ar_id), .axi4_mem_0_bits_ar_addr(ar_addr),
    .axi4_mem_0_bits_ar_len(ar_len), .axi4_mem_0_bits_ar_size(ar_size),
    .axi4_mem_0_bits_ar_burst(ar_burst), .axi4_mem_0_bits_ar_lock(ar_lock),
    .axi4_mem_0_bits_ar_cache(ar_cache), .axi4_mem_0_bits_ar_prot(ar_prot),
    .axi4_mem_0_bits_ar_qos(ar_qos),
    .axi4_mem_0_bits_r_valid(r_valid), .axi4_mem_0_bits_r_ready(r_ready),
    .axi4_mem_0_bits_r_id(r_id), .axi4_mem_0_bits_r_data(r_data),
    .axi4_mem_0_bits_r_resp(r_resp), .axi4_mem_0_bits_r_last(r_last)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [63:0] data; logic err; } cpl_t;
  typedef struct packed { logic [63:0] data; logic [7:0] strb; } wbeat_t;

  cpl_t        exp_q[$];
  logic [31:0] aw_exp_q[$];
  logic [31:0] ar_exp_q[$];
  wbeat_t      w_exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int overlap = 0, busy_gnt = 0, unstable = 0;

  // Slave configuration, set by the stimulus before each transaction.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [63:0] r_data_cfg = '0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [63:0] last_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  initial begin : aw_slave
    aw_ready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (aw_valid && !aw_ready) begin
        for (int i = 0; i < aw_delay; i++) begin @(posedge clk_i); #1; end
        aw_ready = 1'b1;
        @(posedge clk_i); #1;
        aw_ready = 1'b0;
      end
    end
  end

  initial begin : w_slave
    w_ready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (w_valid && !w_ready) begin
        for (int i = 0; i < w_delay; i++) begin @(posedge clk_i); #1; end
        w_ready = 1'b1;
        @(posedge clk_i); #1;
        w_ready = 1'b0;
      end
    end
  end

  initial begin : ar_slave
    ar_ready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (ar_valid && !ar_ready) begin
        for (int i = 0; i < ar_delay; i++) begin @(posedge clk_i); #1; end
        ar_ready = 1'b1;
        @(posedge clk_i); #1;
        ar_ready = 1'b0;
      end
    end
  end

  initial begin : b_slave
    b_valid = 1'b0; b_id = '0; b_resp = 2'b00;
    forever begin
      @(posedge clk_i); #1;
      if (b_ready && !b_valid) begin
        for (int i = 0; i < b_delay; i++) begin @(posedge clk_i); #1; end
        b_valid = 1'b1; b_resp = b_resp_cfg;
        @(posedge clk_i); #1;
        b_valid = 1'b0; b_resp = 2'b00;
      end
    end
  end

  initial begin : r_slave
    r_valid = 1'b0; r_id = '0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (r_ready && !r_valid) begin
        for (int i = 0; i < r_delay; i++) begin @(posedge clk_i); #1; end
        r_valid = 1'b1; r_data = r_data_cfg; r_resp = r_resp_cfg; r_last = 1'b1;
        @(posedge clk_i); #1;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    cpl_t        c;
    wbeat_t      wb;
    logic        p_ar_v, p_ar_hs, p_aw_v, p_aw_hs, p_w_v, p_w_hs;
    logic [31:0] p_ar_a, p_aw_a;
    logic [63:0] p_w_d;
    p_ar_v = 0; p_ar_hs = 0; p_aw_v = 0; p_aw_hs = 0; p_w_v = 0; p_w_hs = 0;
    p_ar_a = '0; p_aw_a = '0; p_w_d = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        p_ar_v = 0; p_aw_v = 0; p_w_v = 0;
      end else begin
        if (rvalid_o) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_rvalid: got rvalid_o=1 rdata 0x%0h, required no completion", rdata_o);
          end else begin
            c = exp_q.pop_front();
            check("rdata", rdata_o, c.data);
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
            check("err", 64'(err_o), 64'(c.err));
`endif
          end
        end
        if (aw_valid && aw_ready) begin
          if (aw_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_aw: got addr 0x%0h, required no AW beat", aw_addr);
          end else check("aw_addr", 64'(aw_addr), 64'(aw_exp_q.pop_front()));
          check("aw_fields", 64'({aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos}),
                64'({4'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
        end
        if (w_valid && w_ready) begin
          if (w_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_w: got data 0x%0h, required no W beat", w_data);
          end else begin
            wb = w_exp_q.pop_front();
            check("w_data", w_data, wb.data);
            check("w_strb_last", 64'({w_strb, w_last}), 64'({wb.strb, 1'b1}));
          end
        end
        if (ar_valid && ar_ready) begin
          if (ar_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_ar: got addr 0x%0h, required no AR beat", ar_addr);
          end else check("ar_addr", 64'(ar_addr), 64'(ar_exp_q.pop_front()));
          check("ar_fields", 64'({ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos}),
                64'({4'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
        end
        if (aw_valid && ar_valid) overlap++;
        if (gnt_o && (aw_valid || w_valid || ar_valid || b_ready || r_ready)) busy_gnt++;
        if (p_ar_v && !p_ar_hs && (!ar_valid || ar_addr != p_ar_a)) unstable++;
        if (p_aw_v && !p_aw_hs && (!aw_valid || aw_addr != p_aw_a)) unstable++;
        if (p_w_v && !p_w_hs && (!w_valid || w_data != p_w_d)) unstable++;
        p_ar_v = ar_valid; p_ar_hs = ar_ready; p_ar_a = ar_addr;
        p_aw_v = aw_valid; p_aw_hs = aw_ready; p_aw_a = aw_addr;
        p_w_v  = w_valid;  p_w_hs  = w_ready;  p_w_d  = w_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [31:0] addr, input logic [63:0] data,
                       input logic [7:0] be);
    req_i = 1'b1; we_i = we; addr_i = addr; data_i = data; be_i = be;
  endtask

  task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] be, input logic err);
    if (we) begin
      aw_exp_q.push_back(addr);
      w_exp_q.push_back(wbeat_t'({data, be}));
      exp_q.push_back(cpl_t'({last_rdata, err}));
    end else begin
      ar_exp_q.push_back(addr);
      exp_q.push_back(cpl_t'({r_data_cfg, err}));
      last_rdata = r_data_cfg;
    end
  endtask

  // Waits on negedges for gnt_o; leaves time at the granting negedge.
  task automatic wait_gnt(input string name);
    int n = 0;
    @(negedge clk_i);
    while (!gnt_o && n < 100) begin @(negedge clk_i); n++; end
    if (!gnt_o) begin
      n_checks++; n_errors++;
      $display("FAIL %s_gnt_timeout: got no gnt_o in 100 cycles, required a grant", name);
    end
  endtask

  task automatic release_req();
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] be, input logic err);
    expect_txn(we, addr, data, be, err);
    @(posedge clk_i); #1;
    drive(we, addr, data, be);
    wait_gnt(name);
    release_req();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk_i); n++; end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk_i);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int n;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; data_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ctrl", 64'({gnt_o, rvalid_o, aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
    check("reset_rdata", rdata_o, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Write with AW accepted two cycles ahead of W.
    aw_delay = 0; w_delay = 2; b_delay = 1;
    issue("wr1", 1'b1, 32'h8000_0010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0);
    wait_done("wr1");

    // Read with a three-cycle data latency.
    ar_delay = 0; r_delay = 3; r_data_cfg = 64'h1122334455667788;
    issue("rd1", 1'b0, 32'h8000_0020, 64'd0, 8'h00, 1'b0);
    wait_done("rd1");

    // Partial-strobe write, AW/W accepted together; rdata_o must not change.
    aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    issue("wr2", 1'b1, 32'h8000_0100, 64'h01234567_89ABCDEF, 8'h0F, 1'b0);
    wait_done("wr2");

    // Read followed by write with req_i held: second grant lands on rvalid_o.
    r_delay = 1; r_data_cfg = 64'hA5A5_5A5A_0F0F_F0F0;
    expect_txn(1'b0, 32'h8000_0040, 64'd0, 8'h00, 1'b0);
    expect_txn(1'b1, 32'h8000_0048, 64'h0BAD_F00D_1234_5678, 8'hF0, 1'b0);
    @(posedge clk_i); #1;
    drive(1'b0, 32'h8000_0040, 64'd0, 8'h00);
    wait_gnt("b2b_rd");
    @(posedge clk_i); #1;
    drive(1'b1, 32'h8000_0048, 64'h0BAD_F00D_1234_5678, 8'hF0);
    wait_gnt("b2b_wr");
    check("b2b_gnt_with_rvalid", 64'(rvalid_o), 64'd1);
    release_req();
    wait_done("b2b");

    // AR stalled ten cycles with req_i held: no grant, AR payload stable.
    ar_delay = 10; r_delay = 0; r_data_cfg = 64'h0F0E_0D0C_0B0A_0908;
    expect_txn(1'b0, 32'h8000_0080, 64'd0, 8'h00, 1'b0);
    @(posedge clk_i); #1;
    drive(1'b0, 32'h8000_0080, 64'd0, 8'h00);
    wait_gnt("stall");
    @(posedge clk_i); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("stall_ar", 64'({gnt_o, ar_valid, ar_addr}), 64'({1'b0, 1'b1, 32'h8000_0080}));
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_done("stall");

    // Reset while waiting for R: transaction dropped silently.
    ar_delay = 0; r_delay = 20; r_data_cfg = 64'hFFFF_EEEE_DDDD_CCCC;
    expect_txn(1'b0, 32'h8000_00C0, 64'd0, 8'h00, 1'b0);
    @(posedge clk_i); #1;
    drive(1'b0, 32'h8000_00C0, 64'd0, 8'h00);
    wait_gnt("rst_rd");
    release_req();
    n = 0;
    while (!r_ready && n < 100) begin @(negedge clk_i); n++; end
    check("rst_reach_wait_r", 64'(r_ready), 64'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid_o}), 64'd0);
    check("rst_mid_rdata", rdata_o, 64'd0);
    exp_q.delete(); ar_exp_q.delete(); aw_exp_q.delete(); w_exp_q.delete();
    last_rdata = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    r_delay = 1; r_data_cfg = 64'h5566_7788_99AA_BBCC;
    issue("post_rst_rd", 1'b0, 32'h8000_00D0, 64'd0, 8'h00, 1'b0);
    wait_done("post_rst_rd");

    // Error responses: flagged only when the error output is built in.
    b_resp_cfg = 2'b10; r_resp_cfg = 2'b00; r_data_cfg = 64'h1357_9BDF_2468_ACE0;
`ifdef ROCKET_MEM_TO_AXI_ERR_EN
    issue("err_wr", 1'b1, 32'h8000_0200, 64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b1);
    wait_done("err_wr");
    b_resp_cfg = 2'b00;
    issue("err_rd", 1'b0, 32'h8000_0208, 64'd0, 8'h00, 1'b0);
    wait_done("err_rd");
`else
    issue("slverr_wr", 1'b1, 32'h8000_0200, 64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b0);
    wait_done("slverr_wr");
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
    issue("decerr_rd", 1'b0, 32'h8000_0208, 64'd0, 8'h00, 1'b0);
    wait_done("decerr_rd");
    r_resp_cfg = 2'b00;
`endif

    repeat (5) @(negedge clk_i);
    check("aw_ar_overlap", 64'(overlap), 64'd0);
    check("gnt_while_busy", 64'(busy_gnt), 64'd0);
    check("valid_stability", 64'(unstable), 64'd0);
    check("beats_left", 64'(aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule
